// File: rtl/icache_l2_refill_responder.sv
// L2-side refill responder: one outstanding Icache miss, line-aligned memory read, BEATS-beat line assembly.
// Optional last-line buffer enabled by defining L2_REFILL_LINEBUF_EN.
module icache_l2_refill_responder #(
  parameter int PA_W   = 34,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_valid,
  output logic              o_miss_ready,
  input  logic [PA_W-1:0]   i_miss_addr_34,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [PA_W-1:0]   o_mem_req_addr_34,
  input  logic              i_mem_rvalid,
  input  logic [BEAT_W-1:0] i_mem_rdata,
  input  logic              i_mem_rlast,
  input  logic              i_mem_rerr,
  output logic              o_refill_valid,
  input  logic              i_refill_ready,
  output logic [LINE_W-1:0] o_refill_line_32B,
  output logic              o_refill_err,
  output logic              o_busy
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam int TAG_W = PA_W - OFF;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BEAT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [PA_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              hit;

`ifdef L2_REFILL_LINEBUF_EN
  logic              lb_valid_q;
  logic [TAG_W-1:0]  lb_tag_q;
  logic [LINE_W-1:0] lb_line_q;

  assign hit = lb_valid_q && (lb_tag_q == i_miss_addr_34[PA_W-1:OFF]);

  // Only clean refills are remembered; any erroneous completion drops the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_line_q  <= '0;
    end else if (state_q == S_RESP && i_refill_ready) begin
      lb_valid_q <= ~err_q;
      if (!err_q) begin
        lb_tag_q  <= addr_q[PA_W-1:OFF];
        lb_line_q <= line_q;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign o_miss_ready      = (state_q == S_IDLE);
  assign o_mem_req_valid   = (state_q == S_REQ);
  assign o_refill_valid    = (state_q == S_RESP);
  assign o_busy            = (state_q != S_IDLE);
  assign o_mem_req_addr_34 = addr_q;
  assign o_refill_line_32B = line_q;
  assign o_refill_err      = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    err_d      = err_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_miss_valid) begin
          addr_d  = {i_miss_addr_34[PA_W-1:OFF], {OFF{1'b0}}};
          state_d = S_REQ;
`ifdef L2_REFILL_LINEBUF_EN
          if (hit) begin
            line_d  = lb_line_q;
            err_d   = 1'b0;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_REQ: begin
        if (i_mem_req_ready) begin
          line_d     = '0;
          err_d      = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_BEAT;
        end
      end
      S_BEAT: begin
        if (i_mem_rvalid) begin
          for (int b = 0; b < BEATS; b++)
            if (beat_cnt_q == CNT_W'(b)) line_d[b*BEAT_W +: BEAT_W] = i_mem_rdata;
          beat_cnt_d = beat_cnt_q + 1'b1;
          err_d      = err_q | i_mem_rerr;
          // rlast must coincide with the final beat; early or missing rlast flags the line.
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            err_d   = err_d | ~i_mem_rlast;
            state_d = S_RESP;
          end else begin
            err_d = err_d | i_mem_rlast;
          end
        end
      end
      S_RESP: begin
        if (i_refill_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  logic unused_hit;
  assign unused_hit = hit;
endmodule
